// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encoding (also used by
// ld_data_rewrite), controller FSM states and default geometry.
package lsu_pkg;

    // Access size select carried from decode through to load rewrite.
    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_BU = 3'd3,
        SZ_HU = 3'd4
    } lsu_size_e;

    // Controller states: idle/accepting, waiting on memory, response pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam int LSU_TIMEOUT_CYCLES = 8;
    localparam int LSU_ADDR_W         = 16;

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane steering: byte enables and replicated write data
// for the low address bits, plus an alignment/size legality flag.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_bmask,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    // Replicate the significant store bytes across the word; memory picks
    // the lanes with the byte mask, so no shifting is needed.
    always_comb begin
        o_bmask      = 4'b0000;
        o_wdata      = 32'h0;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B, SZ_BU: begin
                o_bmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H, SZ_HU: begin
                o_misaligned = i_addr_lo[0];
                o_bmask      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_st_data[15:0]}};
            end
            SZ_W: begin
                o_misaligned = (i_addr_lo != 2'b00);
                o_bmask      = 4'b1111;
                o_wdata      = i_st_data;
            end
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store access controller between the MEM stage and synchronous data
// memory. Handshakes:
//   request : accepted on i_req_valid & o_req_ready (ready only in IDLE);
//             request fields are sampled only on that edge.
//   memory  : o_mem_req held with stable addr/we/bmask/wdata until an edge
//             with i_mem_ack high; i_mem_ack is ignored outside MEM.
//   response: o_rsp_valid is a single-cycle pulse, no back-pressure.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = LSU_ADDR_W,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_lsu_wren,
    input  logic [31:0]       i_lsu_addr,
    input  logic [31:0]       i_st_data,
    input  logic [2:0]        i_size_sel,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_bmask,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_ld_data,
    output logic [1:0]        o_segment_lsu_addr,
    output logic [2:0]        o_rewrite_sel,
    output logic              o_misaligned,
    output logic              o_timeout,
    output lsu_state_e        o_dbg_state
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e         state_q, state_d;
    logic               wren_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [2:0]         size_q;
    logic [3:0]         bmask_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        ld_data_q;
    logic               mis_q;
    logic               tmo_q;

    logic [3:0]         al_bmask;
    logic [31:0]        al_wdata;
    logic               al_mis;
    logic               accept;
    logic               illegal;
    logic               cnt_done;

    // Address bits above the memory window never reach the memory.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^i_lsu_addr[31:ADDR_W+2];

    lsu_store_align u_align (
        .i_addr_lo    (i_lsu_addr[1:0]),
        .i_size       (i_size_sel),
        .i_st_data    (i_st_data),
        .o_bmask      (al_bmask),
        .o_wdata      (al_wdata),
        .o_misaligned (al_mis)
    );

    assign accept   = i_req_valid & (state_q == ST_IDLE);
    // Unsigned sizes have no store form, so they are rejected for stores.
    assign illegal  = al_mis | (i_lsu_wren & ((i_size_sel == SZ_BU) | (i_size_sel == SZ_HU)));
    assign cnt_done = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: illegal requests skip memory; ack beats a same-edge timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = illegal ? ST_RESP : ST_MEM;
                end
            end
            ST_MEM: begin
                if (i_mem_ack || cnt_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; memory fields are driven only while requesting.
    always_comb begin
        o_req_ready = 1'b0;
        o_stall     = 1'b1;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_bmask = 4'b0000;
        o_mem_wdata = 32'h0;
        o_rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_stall     = 1'b0;
            end
            ST_MEM: begin
                o_mem_req   = 1'b1;
                o_mem_we    = wren_q;
                o_mem_addr  = addr_q[ADDR_W+1:2];
                o_mem_bmask = bmask_q;
                o_mem_wdata = wdata_q;
            end
            ST_RESP: o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch on accept, then read capture / timeout counting in MEM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wren_q    <= 1'b0;
            addr_q    <= '0;
            size_q    <= 3'd0;
            bmask_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            ld_data_q <= 32'h0;
            mis_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else if (accept) begin
            wren_q    <= i_lsu_wren;
            addr_q    <= i_lsu_addr[ADDR_W+1:0];
            size_q    <= i_size_sel;
            bmask_q   <= i_lsu_wren ? al_bmask : 4'b1111;
            wdata_q   <= i_lsu_wren ? al_wdata : 32'h0;
            cnt_q     <= '0;
            ld_data_q <= 32'h0;
            mis_q     <= illegal;
            tmo_q     <= 1'b0;
        end else if (state_q == ST_MEM) begin
            if (i_mem_ack) begin
                if (!wren_q) begin
                    ld_data_q <= i_mem_rdata;
                end
            end else if (cnt_done) begin
                tmo_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_ld_data          = ld_data_q;
    assign o_segment_lsu_addr = addr_q[1:0];
    assign o_rewrite_sel      = size_q;
    assign o_misaligned       = mis_q;
    assign o_timeout          = tmo_q;
    assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: transaction-level reference model producing the
// expected per-cycle outputs, a single negedge compare process, directed
// cases with hand-computed values, and randomized traffic.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int AW  = 16;
    localparam int TMO = 8;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_lsu_wren;
    logic [31:0]   i_lsu_addr;
    logic [31:0]   i_st_data;
    logic [2:0]    i_size_sel;
    logic          o_stall;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [3:0]    o_mem_bmask;
    logic [31:0]   o_mem_wdata;
    logic          i_mem_ack;
    logic [31:0]   i_mem_rdata;
    logic          o_rsp_valid;
    logic [31:0]   o_ld_data;
    logic [1:0]    o_segment_lsu_addr;
    logic [2:0]    o_rewrite_sel;
    logic          o_misaligned;
    logic          o_timeout;
    lsu_state_e    dbg_state;

    lsu_mem_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_lsu_wren         (i_lsu_wren),
        .i_lsu_addr         (i_lsu_addr),
        .i_st_data          (i_st_data),
        .i_size_sel         (i_size_sel),
        .o_stall            (o_stall),
        .o_mem_req          (o_mem_req),
        .o_mem_we           (o_mem_we),
        .o_mem_addr         (o_mem_addr),
        .o_mem_bmask        (o_mem_bmask),
        .o_mem_wdata        (o_mem_wdata),
        .i_mem_ack          (i_mem_ack),
        .i_mem_rdata        (i_mem_rdata),
        .o_rsp_valid        (o_rsp_valid),
        .o_ld_data          (o_ld_data),
        .o_segment_lsu_addr (o_segment_lsu_addr),
        .o_rewrite_sel      (o_rewrite_sel),
        .o_misaligned       (o_misaligned),
        .o_timeout          (o_timeout),
        .o_dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        ready;
        logic        stall;
        logic        mem_req;
        logic        rsp;
        logic        we;
        logic [15:0] addr;
        logic [3:0]  bmask;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] ld;
        logic        chk_ld;
        logic [1:0]  seg;
        logic [2:0]  sel;
        logic        mis;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t exp_blank();
        exp_t e;
        e.ready = 0; e.stall = 0; e.mem_req = 0; e.rsp = 0; e.we = 0;
        e.addr = '0; e.bmask = '0; e.wdata = '0; e.chk_wdata = 0;
        e.ld = '0; e.chk_ld = 0; e.seg = '0; e.sel = '0; e.mis = 0; e.tmo = 0;
        return e;
    endfunction

    function automatic exp_t exp_idle();
        exp_t e;
        e = exp_blank();
        e.ready = 1;
        return e;
    endfunction

    // Compare every cycle that has a queued expectation.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            cur_e = exp_q.pop_front();
            chk("req_ready", o_req_ready, cur_e.ready);
            chk("stall", o_stall, cur_e.stall);
            chk("mem_req", o_mem_req, cur_e.mem_req);
            chk("rsp_valid", o_rsp_valid, cur_e.rsp);
            if (cur_e.mem_req) begin
                chk("mem_we", o_mem_we, cur_e.we);
                chk("mem_addr", o_mem_addr, cur_e.addr);
                chk("mem_bmask", o_mem_bmask, cur_e.bmask);
                if (cur_e.chk_wdata) chk("mem_wdata", o_mem_wdata, cur_e.wdata);
            end
            if (cur_e.rsp) begin
                chk("rsp_segment", o_segment_lsu_addr, cur_e.seg);
                chk("rsp_sel", o_rewrite_sel, cur_e.sel);
                chk("rsp_misaligned", o_misaligned, cur_e.mis);
                chk("rsp_timeout", o_timeout, cur_e.tmo);
                if (cur_e.chk_ld) chk("rsp_ld_data", o_ld_data, cur_e.ld);
            end
        end
    end

    // Observation of the DUT used by the literal directed checks.
    int          mem_cyc;
    logic [15:0] seen_addr;
    logic [3:0]  seen_bmask;
    logic [31:0] seen_wdata;
    logic        seen_we;
    logic [31:0] rsp_ld;
    logic [1:0]  rsp_seg;
    logic [2:0]  rsp_sel;
    logic        rsp_mis;
    logic        rsp_tmo;
    logic        stall_log[$];

    always @(negedge i_clk) begin
        stall_log.push_back(o_stall);
        if (o_mem_req) begin
            mem_cyc++;
            seen_addr  = o_mem_addr;
            seen_bmask = o_mem_bmask;
            seen_wdata = o_mem_wdata;
            seen_we    = o_mem_we;
        end
        if (o_rsp_valid) begin
            rsp_ld  = o_ld_data;
            rsp_seg = o_segment_lsu_addr;
            rsp_sel = o_rewrite_sel;
            rsp_mis = o_misaligned;
            rsp_tmo = o_timeout;
        end
    end

    // Final load value as ld_data_rewrite forms it.
    function automatic logic [31:0] ld_rewrite(input logic [31:0] w, input logic [1:0] seg,
                                               input logic [2:0] sel);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*seg +: 8];
        h = seg[1] ? w[31:16] : w[15:0];
        case (sel)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd3:    return {24'h0, b};
            3'd4:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_junk();
        i_req_valid = 1'($urandom);
        i_lsu_wren  = 1'($urandom);
        i_lsu_addr  = $urandom;
        i_st_data   = $urandom;
        i_size_sel  = 3'($urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            drive_junk();
            i_req_valid = 1'b0;
            i_mem_ack   = 1'($urandom);
            i_mem_rdata = $urandom;
            exp_q.push_back(exp_idle());
        end
    endtask

    // One full transaction; ack_dly is the MEM cycle index carrying the ack
    // (negative or >= TMO means memory never answers).
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] st,
                           input logic [2:0] sz, input int ack_dly, input logic [31:0] rd);
        exp_t        e;
        logic        ill;
        logic        acked;
        int          nb;
        int          off;
        logic [3:0]  bm;
        logic [31:0] wd;
        ill = (sz > 3'd4) || (wr && (sz == 3'd3 || sz == 3'd4)) ||
              ((sz == 3'd1 || sz == 3'd4) && addr[0]) || (sz == 3'd2 && addr[1:0] != 2'b00);
        nb  = (sz == 3'd0 || sz == 3'd3) ? 1 : ((sz == 3'd1 || sz == 3'd4) ? 2 : 4);
        off = int'(addr[1:0]);
        bm  = 4'b1111;
        wd  = 32'h0;
        if (wr) begin
            for (int j = 0; j < 4; j++) begin
                bm[j]       = (j >= off) && (j < off + nb);
                wd[8*j +: 8] = st[8*(j % nb) +: 8];
            end
        end
        // accept cycle (IDLE)
        next_cycle();
        i_req_valid = 1'b1;
        i_lsu_wren  = wr;
        i_lsu_addr  = addr;
        i_st_data   = st;
        i_size_sel  = sz;
        i_mem_ack   = 1'($urandom);
        i_mem_rdata = $urandom;
        exp_q.push_back(exp_idle());
        acked = 1'b0;
        if (!ill) begin
            for (int i = 0; i < TMO; i++) begin
                next_cycle();
                drive_junk();
                i_mem_ack   = (i == ack_dly);
                i_mem_rdata = (i == ack_dly) ? rd : $urandom;
                e           = exp_blank();
                e.stall     = 1;
                e.mem_req   = 1;
                e.we        = wr;
                e.addr      = addr[AW+1:2];
                e.bmask     = bm;
                e.wdata     = wd;
                e.chk_wdata = wr;
                exp_q.push_back(e);
                if (i == ack_dly) begin
                    acked = 1'b1;
                    break;
                end
            end
        end
        // response cycle
        next_cycle();
        drive_junk();
        i_mem_ack   = 1'($urandom);
        i_mem_rdata = $urandom;
        e        = exp_blank();
        e.stall  = 1;
        e.rsp    = 1;
        e.seg    = addr[1:0];
        e.sel    = sz;
        e.mis    = ill;
        e.tmo    = !ill && !acked;
        e.chk_ld = !ill;
        e.ld     = (acked && !wr) ? rd : 32'h0;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  sz;
        logic        wr;
        logic [31:0] addr;
        int          d;
        logic        exp_prof[7];

        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_lsu_wren  = 1'b0;
        i_lsu_addr  = 32'h0;
        i_st_data   = 32'h0;
        i_size_sel  = 3'd0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        mem_cyc     = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_stall", o_stall, 0);
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_bmask", o_mem_bmask, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_ld_data", o_ld_data, 0);
        chk("rst_segment", o_segment_lsu_addr, 0);
        chk("rst_sel", o_rewrite_sel, 0);
        chk("rst_misaligned", o_misaligned, 0);
        chk("rst_timeout", o_timeout, 0);
        i_rst_n = 1'b1;
        idle(2);

        // SB to 0x13, ack in first MEM cycle
        mem_cyc = 0;
        run_txn(1'b1, 32'h0000_0013, 32'hAABB_CCDD, 3'd0, 0, 32'h0);
        idle(1);
        chk("sb_mem_cycles", mem_cyc, 1);
        chk("sb_addr", seen_addr, 16'h0004);
        chk("sb_bmask", seen_bmask, 4'b1000);
        chk("sb_wdata", seen_wdata, 32'hDDDD_DDDD);
        chk("sb_we", seen_we, 1);
        chk("sb_flags", {rsp_mis, rsp_tmo}, 2'b00);

        // LH from 0x22, ack in third MEM cycle
        mem_cyc = 0;
        run_txn(1'b0, 32'h0000_0022, $urandom, 3'd1, 2, 32'h8001_7FFF);
        idle(1);
        chk("lh_mem_cycles", mem_cyc, 3);
        chk("lh_ld_data", rsp_ld, 32'h8001_7FFF);
        chk("lh_segment", rsp_seg, 2'b10);
        chk("lh_sel", rsp_sel, 3'd1);
        chk("lh_rewrite", ld_rewrite(rsp_ld, rsp_seg, rsp_sel), 32'hFFFF_8001);

        // illegal accesses never reach memory
        mem_cyc = 0;
        run_txn(1'b0, 32'h0000_0006, 32'h0, 3'd2, 0, 32'h0);
        idle(1);
        chk("lw_mis_flag", rsp_mis, 1);
        run_txn(1'b1, 32'h0000_0001, $urandom, 3'd1, 0, 32'h0);
        idle(1);
        chk("sh_mis_flag", rsp_mis, 1);
        run_txn(1'b1, 32'h0000_0008, $urandom, 3'd3, 0, 32'h0);
        idle(1);
        chk("sbu_mis_flag", rsp_mis, 1);
        chk("mis_mem_cycles", mem_cyc, 0);

        // memory never answers
        mem_cyc = 0;
        run_txn(1'b0, 32'h0000_0040, 32'h0, 3'd2, -1, 32'h0);
        idle(1);
        chk("tmo_mem_cycles", mem_cyc, 8);
        chk("tmo_flag", rsp_tmo, 1);
        chk("tmo_ld_data", rsp_ld, 0);

        // ack on the last MEM cycle wins over timeout
        mem_cyc = 0;
        run_txn(1'b0, 32'h0000_0040, 32'h0, 3'd2, TMO - 1, 32'h1234_5678);
        idle(1);
        chk("late_ack_mem_cycles", mem_cyc, 8);
        chk("late_ack_tmo", rsp_tmo, 0);
        chk("late_ack_ld", rsp_ld, 32'h1234_5678);

        // reset while waiting on memory
        next_cycle();
        i_req_valid = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h0000_0100;
        i_size_sel  = 3'd2; i_mem_ack = 1'b0;
        exp_q.push_back(exp_idle());
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive_junk();
            i_mem_ack = 1'b0;
            cur_e = exp_blank();
            cur_e.stall = 1; cur_e.mem_req = 1; cur_e.we = 0;
            cur_e.addr = 16'h0040; cur_e.bmask = 4'b1111;
            exp_q.push_back(cur_e);
        end
        next_cycle();
        drive_junk();
        i_mem_ack = 1'b0;
        #1;
        chk("pre_rst_mem_req", o_mem_req, 1);
        i_rst_n = 1'b0;
        #1;
        chk("in_rst_mem_req", o_mem_req, 0);
        chk("in_rst_stall", o_stall, 0);
        chk("in_rst_rsp_valid", o_rsp_valid, 0);
        chk("in_rst_req_ready", o_req_ready, 1);
        next_cycle();
        i_rst_n     = 1'b1;
        i_req_valid = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = $urandom;
        exp_q.push_back(exp_idle());
        idle(2);

        // back-to-back with zero-wait ack
        idle(1);
        @(negedge i_clk);
        #1;
        stall_log.delete();
        run_txn(1'b0, 32'h0000_0010, 32'h0, 3'd2, 0, $urandom);
        run_txn(1'b1, 32'h0000_0020, $urandom, 3'd2, 0, 32'h0);
        idle(1);
        @(negedge i_clk);
        #1;
        exp_prof = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        chk("b2b_len", stall_log.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < stall_log.size()) chk($sformatf("b2b_stall_%0d", k), stall_log[k], exp_prof[k]);
        end

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            wr   = 1'($urandom);
            sz   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 3'd2) addr[1:0] = 2'b00;
                if (sz == 3'd1 || sz == 3'd4) addr[0] = 1'b0;
            end
            d = $urandom_range(0, 9);
            run_txn(wr, addr, $urandom, sz, (d >= TMO) ? -1 : d, $urandom);
            d = $urandom_range(0, 2);
            if (d > 0) idle(d);
        end

        idle(2);
        @(negedge i_clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store access controller placed between the MEM-stage request and the synchronous data memory.
- Aligns each request to a word address and generates the byte mask and replicated store data.
- Runs a req/ack handshake with memory, with a timeout.
- Returns raw read word, address byte offset and size select to ld_data_rewrite, which produces the final load value; stalls the pipeline while busy.

Parameters:
- ADDR_W, 16, width of the word-address bus to data memory.
- TIMEOUT_CYCLES, 8, maximum cycles in MEM without i_mem_ack before an error response (>=2).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req_valid  input  1  MEM stage presents a load/store request.
- o_req_ready  output  1  controller idle; request accepted on i_req_valid & o_req_ready.
- i_lsu_wren  input  1  1 = store, 0 = load.
- i_lsu_addr  input  32  byte address.
- i_st_data  input  32  store data (low bytes significant).
- i_size_sel  input  3  0 B, 1 H, 2 W, 3 BU, 4 HU; stores use 0..2 only.
- o_stall  output  1  high whenever state != IDLE.
- o_mem_req  output  1  memory request, held until ack.
- o_mem_we  output  1  memory write enable.
- o_mem_addr  output  ADDR_W  word address = latched addr[ADDR_W+1:2].
- o_mem_bmask  output  4  byte enables.
- o_mem_wdata  output  32  aligned store data.
- i_mem_ack  input  1  memory completion.
- i_mem_rdata  input  32  read word, valid with i_mem_ack.
- o_rsp_valid  output  1  one-cycle response pulse.
- o_ld_data  output  32  captured raw read word (to ld_data_rewrite i_ld_data).
- o_segment_lsu_addr  output  2  latched addr[1:0].
- o_rewrite_sel  output  3  latched i_size_sel.
- o_misaligned  output  1  response flag: misaligned or illegal access.
- o_timeout  output  1  response flag: memory did not ack.

Behaviour:
- Reset:
  - Asynchronous reset forces state IDLE and clears all registers.
  - After reset: o_req_ready=1 in IDLE; every other output is 0.
  - Reset mid-transaction drops o_mem_req immediately; the transaction is lost and no response is produced.
- States: IDLE, MEM, RESP.
- IDLE:
  - o_req_ready=1.
  - On valid&ready, latch wren, addr, st_data and size.
  - Illegal access goes to RESP with misaligned=1 and no memory access. Illegal means any of:
    - size 5..7;
    - store with size 3 or 4;
    - half access (1, 4) with addr[0]=1;
    - word access with addr[1:0]!=0.
  - Otherwise go to MEM and clear the timeout counter.
- MEM:
  - o_mem_req=1; addr, we, bmask and wdata are stable from registered values.
  - On i_mem_ack: capture i_mem_rdata into o_ld_data for loads (0 for stores), then go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack, go to RESP with o_timeout=1 and o_ld_data=0.
  - Ack and timeout on the same edge: ack wins, o_timeout=0.
- RESP:
  - o_rsp_valid=1 for exactly one cycle with ld_data, segment, rewrite_sel and flags stable; then IDLE.
  - Flags clear on the next accept.
- i_mem_ack outside MEM is ignored.
- Inputs are not sampled outside IDLE.
- Latency: accept at edge E0 → o_mem_req high after E0. Ack sampled at E1 → o_rsp_valid in the cycle after E1. Minimum is 2 cycles accept-to-response; 1 for illegal accesses.
- Loads: bmask=4'b1111, we=0.
- Stores, we=1:
  - SB: bmask = 4'b0001 << addr[1:0], wdata = {4{st_data[7:0]}}.
  - SH: bmask = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{st_data[15:0]}}.
  - SW: bmask = 4'b1111, wdata = st_data.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately following RESP.

Decomposition:
- Package lsu_pkg:
  - size-select enum (SZ_B=0, SZ_H=1, SZ_W=2, SZ_BU=3, SZ_HU=4), shared with ld_data_rewrite;
  - FSM state enum;
  - default TIMEOUT_CYCLES.
- One combinational sub-module, lsu_store_align: inputs addr[1:0], size, st_data; outputs bmask, wdata, misaligned.

Test Plan:
- SB, addr 0x0000_0013, st_data 0xAABBCCDD, ack after 1 cycle → mem_addr 0x4, bmask 4'b1000, wdata 0xDDDDDDDD, we=1, rsp_valid 2 cycles after accept, flags 0.
- LH, addr 0x0000_0022, rdata 0x8001_7FFF ack after 3 cycles → o_ld_data 0x80017FFF, segment 2'b10, rewrite_sel 1; ld_data_rewrite output 0xFFFF8001.
- LW, addr 0x0000_0006 → no o_mem_req, rsp_valid next cycle with o_misaligned=1; SH at addr 0x1 and SB with size 3 are also flagged.
- LW, addr 0x40, ack never asserted, TIMEOUT_CYCLES=8 → o_mem_req held 8 cycles, then rsp with o_timeout=1, o_ld_data 0; ack arriving on the final MEM cycle instead gives a normal response.
- Assert i_rst_n=0 during MEM → o_mem_req, o_stall and o_rsp_valid go 0 immediately and o_req_ready=1 after release; a late ack is ignored.
- Two back-to-back requests with zero-wait ack → second accepted in the cycle after the first rsp_valid; o_stall profile 1,1,0,1,1,0.
